// File: rtl/id_ex_stage.sv
// ID/EX operand-issue stage.
// Resolves source operands against three in-flight producers (EX, MEM, WB),
// stalls on results that are not yet available, and latches the resolved
// instruction into the ID/EX register that feeds the ALU.

// Single-operand resolver: zero register, then first matching producer,
// else the register-bank read data. One instance per source operand.
module id_ex_opnd_res #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NSRC   = 3
) (
  input  logic [REG_AW-1:0]            idx,
  input  logic [DATA_W-1:0]            rf,
  input  logic [NSRC-1:0]              fw_wen,
  input  logic [NSRC-1:0][REG_AW-1:0]  fw_rd,
  input  logic [NSRC-1:0][DATA_W-1:0]  fw_data,
  input  logic [NSRC-1:0]              fw_rdy,
  output logic [DATA_W-1:0]            val,
  output logic                         stall
);
  logic hit;

  // Index 0 is the youngest producer and wins; older matches are shadowed.
  // A nonzero idx makes the fw_rd!=0 qualifier implicit.
  always_comb begin
    val   = rf;
    stall = 1'b0;
    hit   = 1'b0;
    if (idx == '0) begin
      val = '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (!hit && fw_wen[i] && (fw_rd[i] == idx)) begin
          hit   = 1'b1;
          val   = fw_data[i];
          stall = ~fw_rdy[i];
        end
      end
    end
  end
endmodule

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_uses_ra,
  input  logic              id_uses_rb,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              fw0_wen,
  input  logic              fw1_wen,
  input  logic              fw2_wen,
  input  logic [REG_AW-1:0] fw0_rd,
  input  logic [REG_AW-1:0] fw1_rd,
  input  logic [REG_AW-1:0] fw2_rd,
  input  logic [DATA_W-1:0] fw0_data,
  input  logic [DATA_W-1:0] fw1_data,
  input  logic [DATA_W-1:0] fw2_data,
  input  logic              fw0_rdy,
  input  logic              fw1_rdy,
  input  logic              fw2_rdy,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam int NSRC = 3;
  localparam int NOPS = 2;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
  } idex_t;

  logic [NSRC-1:0]             fw_wen;
  logic [NSRC-1:0][REG_AW-1:0] fw_rd;
  logic [NSRC-1:0][DATA_W-1:0] fw_data;
  logic [NSRC-1:0]             fw_rdy;

  logic [NOPS-1:0][REG_AW-1:0] src_idx;
  logic [NOPS-1:0][DATA_W-1:0] src_rf;
  logic [NOPS-1:0][DATA_W-1:0] src_val;
  logic [NOPS-1:0]             src_stall;
  logic [NOPS-1:0]             src_uses;

  logic  free;
  logic  accept;
  idex_t idex_q;

  // Producer index order is forwarding priority: EX, MEM, WB.
  assign fw_wen  = {fw2_wen,  fw1_wen,  fw0_wen};
  assign fw_rd   = {fw2_rd,   fw1_rd,   fw0_rd};
  assign fw_data = {fw2_data, fw1_data, fw0_data};
  assign fw_rdy  = {fw2_rdy,  fw1_rdy,  fw0_rdy};

  assign src_idx  = {id_rb, id_ra};
  assign src_rf   = {rf_b, rf_a};
  assign src_uses = {id_uses_rb, id_uses_ra};

  for (genvar g = 0; g < NOPS; g++) begin : g_res
    id_ex_opnd_res #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .NSRC   (NSRC)
    ) u_res (
      .idx     (src_idx[g]),
      .rf      (src_rf[g]),
      .fw_wen  (fw_wen),
      .fw_rd   (fw_rd),
      .fw_data (fw_data),
      .fw_rdy  (fw_rdy),
      .val     (src_val[g]),
      .stall   (src_stall[g])
    );
  end

  // Handshake: a stall only matters for sources the instruction really reads;
  // flush always drains decode.
  always_comb begin
    hazard   = id_valid & (|(src_uses & src_stall));
    free     = ex_ready | ~ex_valid;
    id_ready = flush | (free & ~hazard);
    accept   = id_valid & id_ready & ~flush;
  end

  // ID/EX register and bubble counter; held whenever EX is not free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      idex_q     <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (free) begin
      if (accept) begin
        ex_valid    <= 1'b1;
        idex_q.a    <= src_val[0];
        idex_q.b    <= src_val[1];
        idex_q.imm  <= id_imm;
        idex_q.ctrl <= id_ctrl;
        idex_q.rd   <= id_rd;
      end else begin
        ex_valid <= 1'b0;
        if (hazard && (bubble_cnt != '1))
          bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_a    = idex_q.a;
  assign ex_b    = idex_q.b;
  assign ex_imm  = idex_q.imm;
  assign ex_ctrl = idex_q.ctrl;
  assign ex_rd   = idex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked by a
// reference model (handshake/counter per cycle) and a scoreboard of latched
// instructions popped by an independent output monitor.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;   // small counter so saturation is reachable
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_valid, id_uses_ra, id_uses_rb, flush, ex_ready;
  logic [REG_AW-1:0] id_ra, id_rb, id_rd;
  logic [DATA_W-1:0] id_imm, rf_a, rf_b;
  logic [CTRL_W-1:0] id_ctrl;
  logic              twen [3];
  logic [REG_AW-1:0] trd  [3];
  logic [DATA_W-1:0] tdata[3];
  logic              trdy [3];

  logic              id_ready, ex_valid, hazard;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic [CNT_W-1:0]  bubble_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_a(rf_a), .rf_b(rf_b),
    .fw0_wen(twen[0]), .fw1_wen(twen[1]), .fw2_wen(twen[2]),
    .fw0_rd(trd[0]), .fw1_rd(trd[1]), .fw2_rd(trd[2]),
    .fw0_data(tdata[0]), .fw1_data(tdata[1]), .fw2_data(tdata[2]),
    .fw0_rdy(trdy[0]), .fw1_rdy(trdy[1]), .fw2_rdy(trdy[2]),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .hazard(hazard), .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic mv = 1'b0;     // model: ID/EX holds a live instruction
  int   mcnt = 0;      // model: bubble count

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference operand value: r0 reads zero, else the first producer in
  // EX/MEM/WB order writing that register, else the bank value.
  function automatic void resolve(input logic [REG_AW-1:0] idx, input logic [DATA_W-1:0] rf,
                                  output logic [DATA_W-1:0] v, output logic st);
    v  = rf;
    st = 1'b0;
    if (idx == 0) begin
      v = '0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (twen[i] && trd[i] == idx) begin
        v  = tdata[i];
        st = !trdy[i];
        return;
      end
    end
  endfunction

  // One cycle: inputs are already set at the negedge.
  task automatic step();
    logic [DATA_W-1:0] va, vb;
    logic sa, sb, hz, fr, rdy, acc;
    #1;
    resolve(id_ra, rf_a, va, sa);
    resolve(id_rb, rf_b, vb, sb);
    hz  = id_valid && ((id_uses_ra && sa) || (id_uses_rb && sb));
    fr  = ex_ready || !mv;
    rdy = flush || (fr && !hz);
    acc = id_valid && rdy && !flush;
    chk("hazard", hazard, hz);
    chk("id_ready", id_ready, rdy);
    chk("ex_valid", ex_valid, mv);
    chk("bubble_cnt", bubble_cnt, mcnt);
    @(posedge clk);
    if (flush) mv = 1'b0;
    else if (fr) begin
      if (acc) begin
        mv = 1'b1;
        q.push_back('{va, vb, id_imm, id_ctrl, id_rd});
      end else begin
        mv = 1'b0;
        if (hz && mcnt < CMAX) mcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_uses_ra = 0; id_uses_rb = 0; flush = 0; ex_ready = 1;
    id_ra = 0; id_rb = 0; id_rd = 0; id_imm = 0; id_ctrl = 0; rf_a = 0; rf_b = 0;
    for (int i = 0; i < 3; i++) begin
      twen[i] = 0; trd[i] = 0; tdata[i] = 0; trdy[i] = 1;
    end
  endtask

  task automatic instr(input logic [REG_AW-1:0] ra, input logic [REG_AW-1:0] rb,
                       input logic ua, input logic ub);
    id_valid = 1; id_ra = ra; id_rb = rb; id_uses_ra = ua; id_uses_rb = ub;
    id_rd = REG_AW'($urandom); id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
    rf_a = $urandom; rf_b = $urandom;
  endtask

  // Output monitor: a fresh instruction appears when ex_valid is set and the
  // previous content (if any) was consumed at this edge; otherwise it holds.
  logic last_v = 1'b0;
  logic have = 1'b0;
  exp_t cur;
  always @(posedge clk) begin
    #1;
    if (rst_n && ex_valid) begin
      if (!last_v || ex_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected: output with empty scoreboard, ex_a=%0h", ex_a);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          chk("sb_ex_a", ex_a, cur.a);
          chk("sb_ex_b", ex_b, cur.b);
          chk("sb_ex_imm", ex_imm, cur.imm);
          chk("sb_ex_ctrl", ex_ctrl, cur.ctrl);
          chk("sb_ex_rd", ex_rd, cur.rd);
        end
      end else if (have) begin
        chk("sb_hold", {ex_a, ex_b, ex_imm, ex_ctrl, ex_rd}, cur);
      end
    end
    last_v = ex_valid;
  end

  initial begin
    idle();
    #12;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_a", ex_a, 0);
    chk("rst_ex_b", ex_b, 0);
    chk("rst_ex_imm", ex_imm, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1;

    // zero register ignores a matching r0 producer, even one not ready
    instr(0, 4, 1, 0);
    twen[0] = 1; trd[0] = 0; tdata[0] = 32'hFFFF_FFFF; trdy[0] = 0; rf_a = 32'h99;
    #1 chk("zero_hazard", hazard, 0);
    step();
    chk("zero_ex_a", ex_a, 0);

    // fw0 beats fw1 on the same register
    idle(); instr(7, 2, 1, 1);
    twen[0] = 1; trd[0] = 7; tdata[0] = 32'hAAAA_0000;
    twen[1] = 1; trd[1] = 7; tdata[1] = 32'h5555;
    step();
    chk("prio_ex_a", ex_a, 32'hAAAA_0000);

    // load-use on B: two bubbles then forward
    idle(); instr(1, 3, 1, 1);
    twen[0] = 1; trd[0] = 3; trdy[0] = 0;
    repeat (2) begin
      #1 chk("lu_id_ready", id_ready, 0);
      step();
    end
    trdy[0] = 1; tdata[0] = 32'h42;
    step();
    chk("lu_ex_b", ex_b, 32'h42);
    chk("lu_bubbles", bubble_cnt, 2);

    // same producer, but B is not read: no stall
    idle(); instr(1, 3, 1, 0);
    twen[0] = 1; trd[0] = 3; trdy[0] = 0;
    #1 chk("unused_hazard", hazard, 0);
    step();
    chk("unused_ex_valid", ex_valid, 1);

    // backpressure with a hazard pending: hold, no counting
    idle(); instr(2, 5, 1, 1); ex_ready = 0;
    twen[1] = 1; trd[1] = 5; trdy[1] = 0;
    repeat (3) begin
      #1 chk("bp_id_ready", id_ready, 0);
      step();
    end
    chk("bp_bubbles", bubble_cnt, 2);
    chk("bp_ex_valid", ex_valid, 1);

    // flush with live ID/EX and a live incoming instruction (still hazarded)
    flush = 1;
    #1 chk("fl_id_ready", id_ready, 1);
    step();
    chk("fl_ex_valid", ex_valid, 0);
    chk("fl_bubbles", bubble_cnt, 2);
    flush = 0; ex_ready = 1;
    step();   // third bubble
    chk("bubble3", bubble_cnt, 3);

    // asynchronous reset mid-stream
    idle(); instr(9, 0, 1, 0); rf_a = 32'h1234;
    step();
    idle();
    chk("pre_rst_ex_a", ex_a, 32'h1234);
    #2 rst_n = 0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_a", ex_a, 0);
    chk("arst_bubble_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1; mv = 0; mcnt = 0; q.delete(); have = 0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom % 5) != 0;
      id_ra = REG_AW'($urandom % 8); id_rb = REG_AW'($urandom % 8);
      id_uses_ra = $urandom % 2; id_uses_rb = $urandom % 2;
      id_rd = REG_AW'($urandom); id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
      rf_a = $urandom; rf_b = $urandom;
      for (int i = 0; i < 3; i++) begin
        twen[i] = $urandom % 2; trd[i] = REG_AW'($urandom % 8);
        tdata[i] = $urandom; trdy[i] = ($urandom % 4) != 0;
      end
      ex_ready = ($urandom % 4) != 0;
      flush = ($urandom % 20) == 0;
      step();
    end

    // saturation: far more bubbles than the counter can hold
    idle(); instr(6, 0, 1, 0);
    twen[2] = 1; trd[2] = 6; trdy[2] = 0;
    repeat (CMAX + 5) step();
    chk("sat_bubble_cnt", bubble_cnt, CMAX);

    idle();
    repeat (3) step();
    chk("sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-issue stage directly downstream of the register bank.
- Takes the decoded instruction and the bank's read data (rf_a/rf_b), resolves RAW hazards against three in-flight producer stages, and latches operands and control into the ID/EX pipeline register that feeds the ALU.
- Handshakes upstream (decode) with valid/ready and downstream (EX) with ready.
- Supports flush and counts hazard bubbles.

Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register index width
- CTRL_W, 16, opaque decoded control bundle width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_ra, id_rb  in  REG_AW  source register indices (same as the indices driven to the bank)
- id_uses_ra, id_uses_rb  in  1  source actually read by the instruction
- id_rd  in  REG_AW  destination index
- id_imm  in  DATA_W  immediate
- id_ctrl  in  CTRL_W  control bundle
- rf_a, rf_b  in  DATA_W  register bank read data; stable before posedge
- fw0_wen, fw1_wen, fw2_wen  in  1  producer in EX / MEM / WB will write a register
- fw0_rd, fw1_rd, fw2_rd  in  REG_AW  producer destination index
- fw0_data, fw1_data, fw2_data  in  DATA_W  producer result
- fw0_rdy, fw1_rdy, fw2_rdy  in  1  producer result is valid now (0 e.g. for a load not yet returned)
- flush  in  1  kill ID/EX contents and incoming instruction
- ex_ready  in  1  EX accepts the held instruction
- ex_valid  out  1  ID/EX holds a live instruction
- ex_a, ex_b  out  DATA_W  resolved operands
- ex_imm  out  DATA_W  latched immediate
- ex_ctrl  out  CTRL_W  latched control
- ex_rd  out  REG_AW  latched destination
- hazard  out  1  combinational: unresolvable RAW this cycle
- bubble_cnt  out  CNT_W  hazard bubbles inserted

Behaviour:
- Reset (rst_n=0, async): ex_valid=0; ex_a, ex_b, ex_imm, ex_ctrl, ex_rd and bubble_cnt = 0. The pipeline register is cleared immediately, not at the next edge.
- Operand resolution for A (B identical using id_rb, rf_b):
  - id_ra==0 gives value 0 and is never a hazard.
  - Otherwise search the forwarding sources in priority order fw0 > fw1 > fw2. A source matches when fwN_wen=1, fwN_rd==id_ra and fwN_rd!=0.
  - Only the highest-priority match is used: its fwN_data if fwN_rdy=1. If fwN_rdy=0, a hazard is raised when id_uses_ra=1. Lower-priority matches are ignored.
  - No match: value is rf_a.
  - Same-cycle bank writeback is already visible in rf_a because the bank writes on posedge and reads on negedge, so no fourth source is needed.
- hazard = id_valid & ((id_uses_ra & A-stall) | (id_uses_rb & B-stall)).
- free = ex_ready | ~ex_valid.
- id_ready = flush | (free & ~hazard).
- accept = id_valid & id_ready & ~flush.
- Posedge update, in priority order:
  1. flush=1: ex_valid<=0; the incoming instruction is dropped (id_ready=1 so decode drains); other outputs hold.
  2. free=1 and accept: ex_valid<=1; latch resolved operands, id_imm, id_ctrl, id_rd. Latency is 1 cycle from accept to ex_valid.
  3. free=1 and hazard: ex_valid<=0 (bubble); bubble_cnt increments, saturating at all-ones.
  4. free=1 and id_valid=0: ex_valid<=0.
  5. free=0: all outputs hold; id_ready=0.
- A hazard while free=0 is not counted.
- Flush during a hazard inserts no bubble count.
- Throughput: one instruction per cycle when there is no hazard and ex_ready=1.
- Forwarded values are sampled only at the accept edge. Fresh hazard evaluation every cycle while stalled, so a stall ends as soon as fwN_rdy rises or the producer advances.

Test Plan:
- Reset mid-stream: ex_valid=1, ex_a=0x1234, bubble_cnt=3; assert rst_n=0 between edges -> ex_valid=0, ex_a=0, bubble_cnt=0 immediately, without a clock edge.
- Priority forwarding: id_ra=7; fw0 (rd=7, data=0xAAAA0000, rdy=1) and fw1 (rd=7, data=0x5555) -> ex_a=0xAAAA0000 one cycle after accept.
- Zero register: id_ra=0, fw0_rd=0, fw0_wen=1, fw0_data=0xFFFFFFFF, rf_a=0x99 -> ex_a=0, hazard=0.
- Load-use: id_rb=3, id_uses_rb=1, fw0 (rd=3, rdy=0) for 2 cycles, then rdy=1 with data=0x42 -> id_ready=0 for 2 cycles, two bubbles, bubble_cnt=2, then ex_b=0x42; unused source (id_uses_rb=0, same setup) -> no stall.
- Backpressure: ex_ready=0 for 3 cycles with a hazard pending -> outputs hold, id_ready=0, bubble_cnt unchanged.
- Flush: flush=1 with ex_valid=1 and id_valid=1 -> next edge ex_valid=0, id_ready=1, instruction dropped; counter saturation: preload to 0xFFFF, one more bubble -> stays 0xFFFF.
